fifo_serializer: RTL and testbench

Downstream drain stage for the synchronous FIFO. Pops one word at a time, only when the FIFO reports non-empty, and shifts it out on a single-wire serial line. Each frame is one start bit (0), `fifo_width` data bits LSB first, and one stop bit (1). By construction it never reads from an empty FIFO, so the FIFO's read-on-empty warning check must stay silent in any bench using this block.

---
 rtl/fifo_ser_pkg.sv | 15 +
 rtl/fifo_serializer_if.sv | 36 +++
 rtl/ser_bit_timer.sv | 35 +++
 rtl/fifo_serializer.sv | 110 +++++++++++
 tb/tb_fifo_serializer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO drain serializer.
package fifo_ser_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StStop
    } ser_state_t;

    localparam logic SER_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO-side handshake and serial-line bundle for fifo_serializer.
interface fifo_serializer_if #(
    parameter int unsigned fifo_width = 8
);

    logic                  en;
    logic                  fifo_empty;
    logic [fifo_width-1:0] fifo_data_out;
    logic                  fifo_read;
    logic                  ser_out;
    logic                  busy;
    logic                  frame_done;

    // Environment side: drives FIFO status/data and the enable.
    modport master (
        output en,
        output fifo_empty,
        output fifo_data_out,
        input  fifo_read,
        input  ser_out,
        input  busy,
        input  frame_done
    );

    // Serializer side.
    modport slave (
        input  en,
        input  fifo_empty,
        input  fifo_data_out,
        output fifo_read,
        output ser_out,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period timer: tick marks the last clock of each clks_per_bit period.
module ser_bit_timer #(
    parameter int unsigned clks_per_bit = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(clks_per_bit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    // Next count: wrap at the period end so the counter never overflows.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serializer.sv
// Drains a registered-read FIFO one word at a time onto a start/data/stop serial line.
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned fifo_width   = 8,
    parameter int unsigned clks_per_bit = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_serializer_if.slave bus
);

    localparam int unsigned IdxW = $clog2(fifo_width + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(fifo_width - 1);

    ser_state_t            state_q, state_d;
    logic [fifo_width-1:0] shreg_q, shreg_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  ser_out_q, ser_out_d;
    logic                  tick;
    logic                  timer_clr;

    ser_bit_timer #(
        .clks_per_bit(clks_per_bit)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .tick(tick)
    );

    // Next-state logic; the timer is held cleared until the start bit begins.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        timer_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_clr = 1'b1;
                if (bus.en && !bus.fifo_empty) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                timer_clr = 1'b1;
                state_d   = StLoad;
            end
            StLoad: begin
                // Read data is valid here, one cycle after the pop strobe.
                timer_clr = 1'b1;
                shreg_d   = bus.fifo_data_out;
                idx_d     = '0;
                state_d   = StStart;
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = (bus.en && !bus.fifo_empty) ? StPop : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level for the coming cycle, derived from the next state so the output is registered.
    always_comb begin
        case (state_d)
            StStart: ser_out_d = 1'b0;
            StData:  ser_out_d = shreg_d[0];
            default: ser_out_d = SER_IDLE_LEVEL;
        endcase
    end

    // State, shift register, bit index and line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            idx_q     <= '0;
            ser_out_q <= SER_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            ser_out_q <= ser_out_d;
        end
    end

    assign bus.fifo_read  = (state_q == StPop);
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = (state_q == StStop) && tick;
    assign bus.ser_out    = ser_out_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Randomized bench for fifo_serializer against a frame-timing reference model.
module tb_fifo_serializer;

    localparam int unsigned W        = 8;
    localparam int unsigned CPB      = 4;
    localparam int          FrameCyc = (W + 2) * CPB + 2;  // POP + LOAD + start/data/stop

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_serializer_if #(.fifo_width(W)) bus ();

    fifo_serializer #(
        .fifo_width  (W),
        .clks_per_bit(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // FIFO model: registered read, storage indexed by running push/pop counts.
    logic [W-1:0] mem [256];
    int unsigned  push_cnt = 0;
    int unsigned  pop_cnt  = 0;

    assign bus.fifo_empty = (push_cnt == pop_cnt);

    task automatic push(input logic [W-1:0] d);
        mem[push_cnt[7:0]] = d;
        push_cnt++;
    endtask

    // FIFO read port; a read while empty is reported.
    always @(posedge clk) begin
        if (bus.fifo_read) begin
            check_eq("rd_nonempty", 32'(bus.fifo_empty), 32'd0);
            bus.fifo_data_out <= mem[pop_cnt[7:0]];
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Reference: a frame occupies FrameCyc cycles from its pop; a new pop happens at any edge
    // outside a frame where en and non-empty are seen. Outputs then follow from the offset.
    int           pop_cyc  = -1000;
    int unsigned  exp_rd   = 0;
    logic [W-1:0] cur_word = '0;

    always @(posedge clk) begin
        int         off;
        int         slot;
        logic       in_frame;
        logic       exp_line;
        logic [W+1:0] frame;
        cyc++;
        if (rst) begin
            pop_cyc = -1000;
        end else if (cyc >= pop_cyc + FrameCyc && bus.en && !bus.fifo_empty) begin
            pop_cyc  = cyc;
            cur_word = mem[exp_rd[7:0]];
            exp_rd++;
        end
        #1;
        off      = cyc - pop_cyc;
        in_frame = (off >= 0) && (off < FrameCyc);
        frame    = {1'b1, cur_word, 1'b0};
        exp_line = 1'b1;
        if (in_frame && off >= 2) begin
            slot     = (off - 2) / CPB;
            exp_line = frame[slot];
        end
        check_eq("fifo_read", 32'(bus.fifo_read), 32'(in_frame && off == 0));
        check_eq("busy", 32'(bus.busy), 32'(in_frame));
        check_eq("frame_done", 32'(bus.frame_done), 32'(in_frame && off == FrameCyc - 1));
        check_eq("ser_out", 32'(bus.ser_out), 32'(exp_line));
    end

    initial begin
        bus.en = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_eq("rst_ser_out", 32'(bus.ser_out), 32'd1);
        check_eq("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single word.
        push(8'hA5);
        bus.en = 1'b1;
        repeat (50) @(negedge clk);

        // Back-to-back words.
        push(8'h00);
        push(8'hFF);
        repeat (95) @(negedge clk);

        // Empty FIFO with en toggling.
        repeat (200) begin
            @(negedge clk);
            bus.en = 1'($urandom_range(0, 1));
        end

        // en dropped during DATA with three words queued, then re-raised.
        bus.en = 1'b1;
        repeat (3) push(W'($urandom));
        repeat (15) @(negedge clk);
        bus.en = 1'b0;
        repeat (120) @(negedge clk);
        bus.en = 1'b1;
        repeat (140) @(negedge clk);

        // Reset pulse during data bit 3 of an all-zero word.
        push(8'h00);
        push(8'h3C);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("async_rst_ser_out", 32'(bus.ser_out), 32'd1);
        check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);

        // Random pushes and enable.
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 4 && (push_cnt - pop_cnt) < 6) begin
                push(W'($urandom));
            end
            bus.en = ($urandom_range(0, 9) != 0);
        end
        bus.en = 1'b1;
        repeat (350) @(negedge clk);
        check_eq("drained", push_cnt - pop_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
